// File: rtl/reel_if.sv
// Handshake bundle for the three-reel spin sequencer.
// The master drives the strobes and buttons; the slave (the sequencer) drives the reel state.
interface reel_if;
  logic       spin_tick;
  logic       btn_spin;
  logic       btn_stop;
  logic [2:0] reel0;
  logic [2:0] reel1;
  logic [2:0] reel2;
  logic [2:0] spinning;
  logic       busy;
  logic       result_valid;
  logic       win;

  modport master (
    output spin_tick, btn_spin, btn_stop,
    input  reel0, reel1, reel2, spinning, busy, result_valid, win
  );

  modport slave (
    input  spin_tick, btn_spin, btn_stop,
    output reel0, reel1, reel2, spinning, busy, result_valid, win
  );
endinterface

// File: rtl/reel_controller.sv
// Three-reel spin sequencer: advances reels on spin_tick, stops them one at a time
// on button presses or a tick timeout, and pulses the final result for one cycle.
module reel_controller #(
  parameter int unsigned NUM_SYMBOLS = 8,
  parameter int unsigned AUTO_STOP   = 16
) (
  input logic   clk,
  input logic   rst_n,
  reel_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

  localparam logic [3:0] NumSym    = 4'(NUM_SYMBOLS);
  localparam logic [7:0] StopCount = 8'(AUTO_STOP - 1);

  state_e          state_q, state_d;
  logic [2:0][2:0] reel_q, reel_d;
  logic [2:0]      spin_q, spin_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            win_q, win_d;
  logic            stop_evt;

  function automatic logic [2:0] advance(input logic [2:0] cur, input logic [3:0] step);
    logic [3:0] sum;
    sum = {1'b0, cur} + step;
    if (sum >= NumSym) sum = sum - NumSym;
    return sum[2:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    reel_d   = reel_q;
    spin_d   = spin_q;
    cnt_d    = cnt_q;
    win_d    = 1'b0;
    stop_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.btn_spin) begin
          state_d = StSpin;
          spin_d  = 3'b111;
          cnt_d   = '0;
        end
      end
      StSpin: begin
        stop_evt = bus.btn_stop || (bus.spin_tick && (cnt_q == StopCount));
        if (stop_evt) begin
          // Clear only the lowest set bit, even if press and timeout coincide.
          spin_d = spin_q & (spin_q - 3'd1);
          cnt_d  = '0;
        end else if (bus.spin_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
        // Advance using the post-stop mask so a reel stopped this cycle stays put.
        if (bus.spin_tick) begin
          for (int k = 0; k < 3; k++) begin
            if (spin_d[k]) reel_d[k] = advance(reel_q[k], 4'(k + 1));
          end
        end
        if (stop_evt && (spin_d == 3'b000)) begin
          state_d = StDone;
          win_d   = (reel_d[0] == reel_d[1]) && (reel_d[1] == reel_d[2]);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      reel_q  <= '0;
      spin_q  <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reel_q  <= reel_d;
      spin_q  <= spin_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign bus.reel0        = reel_q[0];
  assign bus.reel1        = reel_q[1];
  assign bus.reel2        = reel_q[2];
  assign bus.spinning     = spin_q;
  assign bus.busy         = (state_q == StSpin);
  assign bus.result_valid = (state_q == StDone);
  assign bus.win          = win_q;

endmodule
